// File: rtl/request_unit_fsm_pkg.sv
// ---------------------------------------------------------------------------
// request_unit_fsm_pkg
// Types and helpers shared by the request unit and its wait counter.
//   ru_state_t    : IDLE / DPEND / HALTED controller state
//   ru_en_t       : data-memory enable pair {ren, wen}
//   ru_decode_en  : turns the datapath's dREN/dWEN into memory enables
//                   (a write always wins over a simultaneous read)
// ---------------------------------------------------------------------------
package request_unit_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DPEND  = 2'd1,
    HALTED = 2'd2
  } ru_state_t;

  typedef struct packed {
    logic ren;
    logic wen;
  } ru_en_t;

  function automatic ru_en_t ru_decode_en(input logic dren, input logic dwen);
    ru_en_t en;
    en.wen = dwen;
    en.ren = dren & ~dwen;
    return en;
  endfunction

endpackage

// File: rtl/ru_wait_counter.sv
// ---------------------------------------------------------------------------
// ru_wait_counter
// Saturating wait-cycle counter for the request unit.
//   CLK, nRST : clock, asynchronous active-low reset
//   clr       : synchronous clear to 0 (has priority over en)
//   en        : count one cycle; holds at 2^CNT_W-1
//   cnt       : current count
//   tc        : terminal count, high while cnt == TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module ru_wait_counter #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !(&cnt)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/request_unit_fsm.sv
// ---------------------------------------------------------------------------
// request_unit_fsm
// Request unit between datapath and memory control. Keeps instruction fetch
// running, captures one data request per accepting ihit, holds address, store
// data and enables stable until dhit, counts wait cycles and supports a
// sticky halt.
//
// Optional feature: define REQ_TIMEOUT_EN to abort a request that waits
// TIMEOUT_CYCLES cycles without dhit (req_timeout pulses). Without it the
// unit waits indefinitely and req_timeout is tied to 0.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit                 datapath accepts an instruction this cycle
//   dhit                 data access complete
//   dREN, dWEN           datapath data request (valid with ihit)
//   daddr, dstore        datapath address / store data
//   halt                 datapath halt
//   imemREN              instruction read enable (decoded from state)
//   dmemREN, dmemWEN     registered data enables
//   dmemaddr, dmemstore  latched address / store data
//   busy, halted         state DPEND / state HALTED
//   dwait_cnt            cycles spent in current/most recent DPEND
//   req_err              1-cycle pulse: dREN and dWEN both set on accept
//   req_timeout          1-cycle pulse: request aborted by timeout
// ---------------------------------------------------------------------------
module request_unit_fsm
  import request_unit_fsm_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned STALL_IFETCH   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic              halt,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  dwait_cnt,
  output logic              req_err,
  output logic              req_timeout
);

  typedef struct packed {
    ru_en_t            en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] store;
  } ru_req_t;

  ru_state_t state_q, state_d;
  ru_req_t   req_q, req_d, new_req;
  logic      err_q, err_d;
  logic      halt_pend_q, halt_pend_d;
  logic      cnt_clr, cnt_tc;
  logic      accept;

  assign accept  = ihit & (dREN | dWEN);
  assign new_req = '{en: ru_decode_en(dREN, dWEN), addr: daddr, store: dstore};

`ifdef REQ_TIMEOUT_EN
  logic tmo_q, tmo_d;
`endif

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    err_d       = 1'b0;
    halt_pend_d = halt_pend_q;
    cnt_clr     = 1'b0;
`ifdef REQ_TIMEOUT_EN
    tmo_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = DPEND;
          req_d       = new_req;
          err_d       = dREN & dWEN;
          cnt_clr     = 1'b1;
          // A halt arriving with the request waits for it to complete.
          halt_pend_d = halt;
        end else if (halt) begin
          state_d = HALTED;
        end
      end
      DPEND: begin
        if (dhit) begin
          halt_pend_d = 1'b0;
          if (halt || halt_pend_q) begin
            state_d  = HALTED;
            req_d.en = '0;
          end else if (accept) begin
            // Back-to-back reload: enables stay high, no idle gap.
            req_d   = new_req;
            err_d   = dREN & dWEN;
            cnt_clr = 1'b1;
          end else begin
            state_d  = IDLE;
            req_d.en = '0;
          end
        end
`ifdef REQ_TIMEOUT_EN
        else if (cnt_tc) begin
          halt_pend_d = 1'b0;
          state_d     = (halt || halt_pend_q) ? HALTED : IDLE;
          req_d.en    = '0;
          tmo_d       = 1'b1;
        end
`endif
        else if (halt) begin
          halt_pend_d = 1'b1;
        end
      end
      HALTED: begin
        // Sticky until reset; all inputs ignored.
      end
      default: begin
        state_d  = IDLE;
        req_d.en = '0;
      end
    endcase
  end

  // NOTE: all registers, including the latched address/data, take a reset
  // value so nothing leaves reset as X.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      req_q       <= '0;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  ru_wait_counter #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_counter (
    .CLK (CLK),
    .nRST(nRST),
    .clr (cnt_clr),
    .en  (state_q == DPEND),
    .cnt (dwait_cnt),
    .tc  (cnt_tc)
  );

`ifdef REQ_TIMEOUT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
  assign req_timeout = tmo_q;
`else
  logic unused_tc;
  assign unused_tc   = cnt_tc;
  assign req_timeout = 1'b0;
`endif

  assign imemREN   = (state_q == IDLE) | ((state_q == DPEND) & (STALL_IFETCH == 0));
  assign busy      = (state_q == DPEND);
  assign halted    = (state_q == HALTED);
  assign dmemREN   = req_q.en.ren;
  assign dmemWEN   = req_q.en.wen;
  assign dmemaddr  = req_q.addr;
  assign dmemstore = req_q.store;
  assign req_err   = err_q;

endmodule
